// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: per-ghost scatter/chase/frightened/eaten sequencer driving rotate and update strobes
module ghost_mode_ctrl #(
  parameter int TICK_DIV         = 16,
  parameter int SCATTER_TICKS    = 7,
  parameter int CHASE_TICKS      = 20,
  parameter int NUM_SCATTER      = 4,
  parameter int FRIGHT_TICKS     = 6,
  parameter int FRIGHT_LEVEL_MAX = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] level,
  input  logic       power_eaten,
  input  logic       ghost_caught,
  input  logic       at_house,
  output logic [3:0] mode,
  output logic       rotate,
  output logic       update,
  output logic [3:0] sched_phase
);
  typedef enum logic [1:0] {SCHED, FRIGHT, EATEN} state_t;
  localparam logic [15:0] TLAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] THALF = 16'(TICK_DIV / 2);
  localparam logic [3:0]  PLAST = 4'(2 * NUM_SCATTER - 1);
  localparam logic [7:0]  SLOAD = 8'(SCATTER_TICKS - 1);
  localparam logic [7:0]  CLOAD = 8'(CHASE_TICKS - 1);
  localparam logic [7:0]  FLOAD = 8'(FRIGHT_TICKS - 1);
  state_t      state, state_n;
  logic [15:0] tcnt, tcnt_n;
  logic [7:0]  pcnt, pcnt_n, fcnt, fcnt_n;
  logic [3:0]  phase_n;
  logic        pend_p, pend_c, run, run_n, rot_n, upd_n;
  logic        tick, pwr, cgt;
  assign tick = enable && tcnt == TLAST;
  assign pwr  = (pend_p || power_eaten) && int'(level) < FRIGHT_LEVEL_MAX;
  assign cgt  = pend_c || ghost_caught;
  // the last phase index is odd, so an even phase is always a scatter phase
  assign mode = state == FRIGHT ? 4'b0010 : state == EATEN ? 4'b0001 :
                !sched_phase[0] ? 4'b0100 : 4'b1000;
  // next-state: tick counter, strobes, schedule and mode transitions at tick boundaries
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    pcnt_n  = pcnt;
    fcnt_n  = fcnt;
    phase_n = sched_phase;
    rot_n   = rotate;
    upd_n   = update;
    run_n   = run;
    if (enable) begin
      tcnt_n = tick ? 16'd0 : tcnt + 16'd1;
      upd_n  = tcnt_n < THALF;
      if (tcnt_n == THALF) rot_n = 1'b0;
    end
    if (tick) begin
      run_n = 1'b1;
      case (state)
        SCHED: begin
          // the first boundary after reset only starts phase 0; later ones retire a scheduled pulse
          if (run) begin
            if (pcnt != 8'd0) pcnt_n = pcnt - 8'd1;
            else if (sched_phase != PLAST) begin
              phase_n = sched_phase + 4'd1;
              pcnt_n  = sched_phase[0] ? SLOAD : CLOAD;
              rot_n   = 1'b1;
            end
          end
          if (pwr) begin
            state_n = FRIGHT;
            fcnt_n  = FLOAD;
            rot_n   = 1'b1;
          end
        end
        FRIGHT: begin
          if (cgt) state_n = EATEN;
          else if (pwr) begin
            fcnt_n = FLOAD;
            rot_n  = 1'b1;
          end
          else if (fcnt == 8'd0) state_n = SCHED;
          else fcnt_n = fcnt - 8'd1;
        end
        EATEN: state_n = at_house ? SCHED : EATEN;
        default: state_n = SCHED;
      endcase
    end
  end
  // state registers; pending events latch in any cycle and clear at each boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SCHED;
      tcnt        <= TLAST;
      pcnt        <= SLOAD;
      fcnt        <= 8'd0;
      sched_phase <= 4'd0;
      rotate      <= 1'b0;
      update      <= 1'b0;
      pend_p      <= 1'b0;
      pend_c      <= 1'b0;
      run         <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      pcnt        <= pcnt_n;
      fcnt        <= fcnt_n;
      sched_phase <= phase_n;
      rotate      <= rot_n;
      update      <= upd_n;
      pend_p      <= tick ? 1'b0 : pend_p || power_eaten;
      pend_c      <= tick ? 1'b0 : pend_c || ghost_caught;
      run         <= run_n;
    end
  end
endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// tb_ghost_mode_ctrl: vector table, directed corner sequences and random ticks against a pulse-level model
module tb_ghost_mode_ctrl;
  localparam int TD = 16, ST = 7, CT = 20, NS = 4, FT = 6, LMAX = 19;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       power_eaten = 1'b0;
  logic       ghost_caught = 1'b0;
  logic       at_house = 1'b0;
  logic [4:0] level = 5'd1;
  logic [3:0] mode, sched_phase;
  logic       rotate, update;
  int checks = 0, errors = 0;
  int m_st, m_phase, m_done, m_fleft;
  bit m_rot, m_first;
  typedef struct {
    int pw; int ct; bit ah; int pause;
    logic [4:0] lvl; logic [3:0] mode; bit rot; logic [3:0] phase;
  } vec_t;
  vec_t tab[$];

  ghost_mode_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable), .level(level),
    .power_eaten(power_eaten), .ghost_caught(ghost_caught), .at_house(at_house),
    .mode(mode), .rotate(rotate), .update(update), .sched_phase(sched_phase)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int plen(input int p);
    return (p % 2) ? CT : ST;
  endfunction

  function automatic logic [3:0] emode();
    if (m_st == 1) return 4'b0010;
    if (m_st == 2) return 4'b0001;
    return (m_phase % 2 == 0 && m_phase < 2 * NS) ? 4'b0100 : 4'b1000;
  endfunction

  // one boundary: m_done counts scheduled pulses finished in the phase, m_fleft frightened pulses still owed
  function automatic void model_step(input bit pw, input bit ct, input bit ah);
    m_rot = 1'b0;
    if (m_st == 0 && !m_first) begin
      m_done++;
      if (m_done == plen(m_phase) && m_phase < 2 * NS - 1) begin
        m_phase++;
        m_done = 0;
        m_rot = 1'b1;
      end
    end
    m_first = 1'b0;
    if (m_st == 0) begin
      if (pw) begin m_st = 1; m_fleft = FT; m_rot = 1'b1; end
    end else if (m_st == 1) begin
      if (ct) m_st = 2;
      else if (pw) begin m_fleft = FT; m_rot = 1'b1; end
      else begin m_fleft--; if (m_fleft == 0) m_st = 0; end
    end else if (ah) m_st = 0;
  endfunction

  task automatic chk_out();
    chk("mode", mode, emode());
    chk("rotate", rotate, m_rot);
    chk("phase", sched_phase, m_phase[3:0]);
    chk("update_rise", update, 1'b1);
  endtask

  // one game tick; pw_at/ct_at are cycle indices (15 = boundary cycle), pause_at inserts 50 disabled cycles
  task automatic run_tick(input int pw_at, input int ct_at, input bit ah, input int pause_at);
    logic [3:0] sm, sp;
    logic su, sr;
    int hi = 0;
    at_house = ah;
    for (int i = 0; i < TD; i++) begin
      hi += int'(update);
      if (i == 4) chk("rot_mid_high", rotate, m_rot);
      if (i == 8) begin
        chk("update_low", update, 1'b0);
        chk("rot_cleared", rotate, 1'b0);
        chk("mode_stable", mode, emode());
      end
      if (i == pause_at) begin
        sm = mode; sp = sched_phase; su = update; sr = rotate;
        enable = 1'b0;
        power_eaten = (pw_at == i);
        for (int k = 0; k < 50; k++) begin
          cyc();
          power_eaten = 1'b0;
        end
        chk("pause_update", update, su);
        chk("pause_rotate", rotate, sr);
        chk("pause_mode", mode, sm);
        chk("pause_phase", sched_phase, sp);
        enable = 1'b1;
      end
      power_eaten = (i == pw_at && i != pause_at);
      ghost_caught = (i == ct_at);
      cyc();
    end
    power_eaten = 1'b0;
    ghost_caught = 1'b0;
    chk("update_high_count", 16'(hi), 16'(TD / 2));
    model_step(pw_at >= 0 && level < LMAX, ct_at >= 0, ah);
    chk_out();
  endtask

  task automatic start_up();
    m_st = 0; m_phase = 0; m_done = 0; m_fleft = 0; m_first = 1'b1; m_rot = 1'b0;
    enable = 1'b1;
    cyc();
    model_step(1'b0, 1'b0, 1'b0);
    chk_out();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mode"}, mode, 4'b0100);
    chk({tag, "_rotate"}, rotate, 1'b0);
    chk({tag, "_update"}, update, 1'b0);
    chk({tag, "_phase"}, sched_phase, 4'd0);
  endtask

  task automatic do_reset();
    enable = 1'b0; power_eaten = 1'b0; ghost_caught = 1'b0; at_house = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk_reset("rst");
    start_up();
  endtask

  function automatic void add(input int pw, input int ct, input bit ah, input int pause,
                              input logic [4:0] lv, input logic [3:0] md, input bit rt,
                              input logic [3:0] ph);
    vec_t v;
    v.pw = pw; v.ct = ct; v.ah = ah; v.pause = pause;
    v.lvl = lv; v.mode = md; v.rot = rt; v.phase = ph;
    tab.push_back(v);
  endfunction

  initial begin
    int rots;
    add(-1, -1, 0, -1, 5'd1, 4'b0100, 0, 4'd0);
    add(-1, -1, 0, -1, 5'd1, 4'b0100, 0, 4'd0);
    add( 5, -1, 0, -1, 5'd1, 4'b0010, 1, 4'd0);
    for (int k = 0; k < 5; k++) add(-1, -1, 0, -1, 5'd1, 4'b0010, 0, 4'd0);
    for (int k = 0; k < 4; k++) add(-1, -1, 0, -1, 5'd1, 4'b0100, 0, 4'd0);
    add(-1, -1, 0, -1, 5'd1, 4'b1000, 1, 4'd1);
    add( 3, -1, 0, -1, 5'd1, 4'b0010, 1, 4'd1);
    add( 2,  9, 0, -1, 5'd1, 4'b0001, 0, 4'd1);
    for (int k = 0; k < 10; k++) add(k == 2 ? 4 : -1, -1, 0, -1, 5'd1, 4'b0001, 0, 4'd1);
    add(-1, -1, 1, -1, 5'd1,  4'b1000, 0, 4'd1);
    add( 6, -1, 0, -1, 5'd19, 4'b1000, 0, 4'd1);
    add(15, -1, 0, -1, 5'd1,  4'b0010, 1, 4'd1);
    add(-1, 15, 0, -1, 5'd1,  4'b0001, 0, 4'd1);
    add(-1, -1, 1, -1, 5'd1,  4'b1000, 0, 4'd1);
    add(-1, -1, 0,  5, 5'd1,  4'b1000, 0, 4'd1);
    add( 3, -1, 0,  3, 5'd1,  4'b0010, 1, 4'd1);

    do_reset();
    foreach (tab[r]) begin
      level = tab[r].lvl;
      run_tick(tab[r].pw, tab[r].ct, tab[r].ah, tab[r].pause);
      chk($sformatf("tab%0d_mode", r), mode, tab[r].mode);
      chk($sformatf("tab%0d_rotate", r), rotate, tab[r].rot);
      chk($sformatf("tab%0d_phase", r), sched_phase, tab[r].phase);
    end

    do_reset();
    level = 5'd1;
    for (int t = 0; t < NS * ST + (NS - 1) * CT; t++) run_tick(-1, -1, 0, -1);
    chk("perm_phase_entry", sched_phase, 4'd7);
    rots = 0;
    for (int t = 0; t < 30; t++) begin
      run_tick(-1, -1, 0, -1);
      rots += int'(rotate);
    end
    chk("perm_rot_count", 16'(rots), 16'd0);
    chk("perm_phase", sched_phase, 4'd7);
    chk("perm_mode", mode, 4'b1000);

    do_reset();
    level = 5'd1;
    run_tick(2, -1, 0, -1);
    chk("pre_rst_fright", mode, 4'b0010);
    power_eaten = 1'b1;
    cyc();
    power_eaten = 1'b0;
    cyc();
    #3 reset = 1'b1;
    #1;
    chk_reset("midrst");
    cyc();
    reset = 1'b0;
    start_up();

    for (int t = 0; t < 200; t++) begin
      level = 5'($urandom_range(0, 31));
      run_tick(($urandom % 4 == 0) ? int'($urandom_range(0, TD - 1)) : -1,
               ($urandom % 4 == 0) ? int'($urandom_range(0, TD - 1)) : -1,
               ($urandom % 3 == 0),
               ($urandom % 10 == 0) ? int'($urandom_range(0, TD - 1)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
